// File: rtl/wb_stage_if.sv
// Bundle of the write-back stage's pipeline inputs, register-file write port and
// decode-stage bypass port. The master modport drives the stage; the slave modport is the stage.
interface wb_stage_if #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
);
    logic                   Stall;
    logic                   Flush;
    logic                   MEM_Valid;
    logic                   MEM_RegWrite;
    logic                   MEM_MemtoReg;
    logic                   MEM_ALUMemOrPC;
    logic [RegAddrBits-1:0] MEM_WriteRegister;
    logic [NBits-1:0]       MEM_ALUResult;
    logic [NBits-1:0]       MEM_ReadData;
    logic [NBits-1:0]       MEM_PCPlus4;
    logic [RegAddrBits-1:0] ID_ReadRegister1;
    logic [RegAddrBits-1:0] ID_ReadRegister2;
    logic [NBits-1:0]       ID_ReadData1_in;
    logic [NBits-1:0]       ID_ReadData2_in;
    logic                   RF_RegWrite;
    logic [RegAddrBits-1:0] RF_WriteRegister;
    logic [NBits-1:0]       RF_WriteData;
    logic [NBits-1:0]       ID_ReadData1_out;
    logic [NBits-1:0]       ID_ReadData2_out;
    logic                   Retire;
    logic [31:0]            RetireCount;

    modport master (
        output Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_ALUMemOrPC,
               MEM_WriteRegister, MEM_ALUResult, MEM_ReadData, MEM_PCPlus4,
               ID_ReadRegister1, ID_ReadRegister2, ID_ReadData1_in, ID_ReadData2_in,
        input  RF_RegWrite, RF_WriteRegister, RF_WriteData,
               ID_ReadData1_out, ID_ReadData2_out, Retire, RetireCount
    );

    modport slave (
        input  Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_ALUMemOrPC,
               MEM_WriteRegister, MEM_ALUResult, MEM_ReadData, MEM_PCPlus4,
               ID_ReadRegister1, ID_ReadRegister2, ID_ReadData1_in, ID_ReadData2_in,
        output RF_RegWrite, RF_WriteRegister, RF_WriteData,
               ID_ReadData1_out, ID_ReadData2_out, Retire, RetireCount
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back select, register-file write port,
// write-before-read bypass of the decode read ports and a retired-instruction counter.
module wb_stage #(
    parameter int NBits        = 32,
    parameter int RegAddrBits  = 5,
    parameter int LinkRegister = 31
) (
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave wb
);
    localparam logic [RegAddrBits-1:0] LinkAddr = RegAddrBits'(LinkRegister);

    logic                   validQ;
    logic                   regWriteQ;
    logic                   memToRegQ;
    logic                   aluMemOrPcQ;
    logic [RegAddrBits-1:0] writeRegisterQ;
    logic [NBits-1:0]       aluResultQ;
    logic [NBits-1:0]       readDataQ;
    logic [NBits-1:0]       pcPlus4Q;
    logic [31:0]            retireCountQ;

    logic [NBits-1:0]       writeData;
    logic [RegAddrBits-1:0] writeRegister;
    logic                   regWriteEn;
    logic                   retire;
    logic [NBits-1:0]       readData1;
    logic [NBits-1:0]       readData2;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ         <= 1'b0;
            regWriteQ      <= 1'b0;
            memToRegQ      <= 1'b0;
            aluMemOrPcQ    <= 1'b0;
            writeRegisterQ <= '0;
            aluResultQ     <= '0;
            readDataQ      <= '0;
            pcPlus4Q       <= '0;
        end else if (wb.Flush) begin
            // A bubble only needs its valid and write-enable bits cleared.
            validQ    <= 1'b0;
            regWriteQ <= 1'b0;
        end else if (!wb.Stall) begin
            validQ         <= wb.MEM_Valid;
            regWriteQ      <= wb.MEM_RegWrite;
            memToRegQ      <= wb.MEM_MemtoReg;
            aluMemOrPcQ    <= wb.MEM_ALUMemOrPC;
            writeRegisterQ <= wb.MEM_WriteRegister;
            aluResultQ     <= wb.MEM_ALUResult;
            readDataQ      <= wb.MEM_ReadData;
            pcPlus4Q       <= wb.MEM_PCPlus4;
        end
    end

    // A stalled instruction is counted once, on the cycle the stall releases.
    assign retire = validQ & ~wb.Stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireCountQ <= '0;
        end else if (retire) begin
            retireCountQ <= retireCountQ + 32'd1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        writeData     = aluResultQ;
        writeRegister = writeRegisterQ;
        if (aluMemOrPcQ) begin
            writeData     = pcPlus4Q;
            writeRegister = LinkAddr;
        end else if (memToRegQ) begin
            writeData = readDataQ;
        end
        regWriteEn = validQ & regWriteQ & (writeRegister != '0);
    end

    // Gating on regWriteEn already keeps reads of $0 from being bypassed.
    always_comb begin
        readData1 = wb.ID_ReadData1_in;
        readData2 = wb.ID_ReadData2_in;
        if (regWriteEn && (writeRegister == wb.ID_ReadRegister1)) readData1 = writeData;
        if (regWriteEn && (writeRegister == wb.ID_ReadRegister2)) readData2 = writeData;
    end

    assign wb.RF_RegWrite      = regWriteEn;
    assign wb.RF_WriteRegister = writeRegister;
    assign wb.RF_WriteData     = writeData;
    assign wb.ID_ReadData1_out = readData1;
    assign wb.ID_ReadData2_out = readData2;
    assign wb.Retire           = retire;
    assign wb.RetireCount      = retireCountQ;
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back select for the 32-bit MIPS pipeline; the writer-side counterpart of the decode/register-read stage.
- Captures MEM-stage results each clock and selects the write data (ALU result, memory data or PC+4 for jal).
- Drives the register-file write port: enable, address and data.
- Provides write-before-read bypass of the two decode-stage read ports, and counts retired instructions.

Parameters:
- NBits, 32, datapath width
- RegAddrBits, 5, register address width
- LinkRegister, 31, destination register forced when ALUMemOrPC=1 (jal)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- Stall  in  1  hold the stage register contents
- Flush  in  1  replace the captured instruction with a bubble
- MEM_Valid  in  1  MEM stage holds a real instruction
- MEM_RegWrite  in  1  instruction writes a register
- MEM_MemtoReg  in  1  1 selects memory data, 0 selects ALU result
- MEM_ALUMemOrPC  in  1  1 selects PC+4 and the link register
- MEM_WriteRegister  in  RegAddrBits  destination register
- MEM_ALUResult  in  NBits  ALU result
- MEM_ReadData  in  NBits  data-memory read data
- MEM_PCPlus4  in  NBits  PC+4 of the instruction
- ID_ReadRegister1  in  RegAddrBits  decode rs address
- ID_ReadRegister2  in  RegAddrBits  decode rt address
- ID_ReadData1_in  in  NBits  raw register-file read port 1
- ID_ReadData2_in  in  NBits  raw register-file read port 2
- RF_RegWrite  out  1  register-file write enable
- RF_WriteRegister  out  RegAddrBits  register-file write address
- RF_WriteData  out  NBits  register-file write data
- ID_ReadData1_out  out  NBits  bypassed read data 1
- ID_ReadData2_out  out  NBits  bypassed read data 2
- Retire  out  1  one-cycle pulse per retired instruction
- RetireCount  out  32  retired-instruction counter

Behaviour:
- Stage register, 1-cycle latency: on the rising clk edge every MEM_* field is captured into the *_q registers.
  - Stall=1: all *_q hold.
  - Flush=1: valid_q and regwrite_q clear to 0; the other fields are don't-care.
  - Flush has priority over Stall.
- reset=0, asynchronous: valid_q, regwrite_q, memtoreg_q, alumemorpc_q, the address, all data registers and RetireCount go to 0. Consequently RF_RegWrite=0, RF_WriteRegister=0, RF_WriteData=0 and Retire=0. The bypass outputs equal their *_in inputs.
- Write-back, combinational from *_q:
  - RF_WriteData = alumemorpc_q ? pcplus4_q : (memtoreg_q ? readdata_q : aluresult_q).
  - RF_WriteRegister = alumemorpc_q ? LinkRegister : writeregister_q.
  - RF_RegWrite = valid_q & regwrite_q & (RF_WriteRegister != 0). Writes to $0 are always suppressed.
- Bypass, combinational, covering the register file's same-cycle write/read:
  - ID_ReadData1_out = (RF_RegWrite && RF_WriteRegister==ID_ReadRegister1) ? RF_WriteData : ID_ReadData1_in.
  - Port 2 is identical using ID_ReadRegister2.
  - A read of $0 is never bypassed; this follows from the RF_RegWrite gating.
- Retire = valid_q & ~Stall.
  - While stalled, the same instruction keeps asserting RF_RegWrite, which is idempotent, but is counted once: on the cycle the stall releases.
- RetireCount increments by 1 on each clk edge where Retire=1 and wraps from 0xFFFFFFFF to 0. No saturation.
- Reset asserted mid-stall or mid-write: the state clears immediately; no partial write is required to complete.
- Flush asserted with MEM_Valid=0: still a bubble. MEM_Valid=0 alone also gives a bubble; RF_RegWrite is then 0 regardless of MEM_RegWrite.

Test Plan:
- Reset, then R-type add:
  - Stimulus: release reset; MEM_Valid=1, RegWrite=1, MemtoReg=0, ALUMemOrPC=0, WriteRegister=8, ALUResult=0x0000_0015.
  - Next cycle: RF_RegWrite=1, RF_WriteRegister=8, RF_WriteData=0x15, Retire=1, RetireCount becomes 1 after that edge.
- lw then jal:
  - Stimulus: lw with MemtoReg=1, ReadData=0xDEAD_BEEF, WriteRegister=9; next, jal with ALUMemOrPC=1, PCPlus4=0x0040_0008, WriteRegister=0.
  - Response: RF_WriteData is 0xDEADBEEF to $9, then 0x00400008 to $31.
- Write to $0:
  - Stimulus: RegWrite=1, WriteRegister=0, ALUResult=0x1234.
  - Response: RF_RegWrite=0; the bypass does not fire for ID_ReadRegister1=0; Retire=1 still.
- Bypass:
  - Stimulus: WB writes 0xCAFE to $10; ID_ReadRegister1=10, ID_ReadRegister2=11, ID_ReadData1_in=0x0, ID_ReadData2_in=0x77.
  - Response: ID_ReadData1_out=0xCAFE, ID_ReadData2_out=0x77.
- Stall and Flush:
  - Stimulus: Stall=1 for 3 cycles with an add to $8 captured.
    - Response: RF outputs hold for 3 cycles; Retire=0 during the stall, then Retire=1 once; RetireCount advances by exactly 1.
  - Stimulus: Stall=1 and Flush=1 in the same cycle.
    - Response: bubble, RF_RegWrite=0 next cycle.
- Wrap and async reset:
  - Stimulus: force RetireCount to 0xFFFF_FFFF and retire one instruction.
    - Response: RetireCount=0.
  - Stimulus: drop reset between clk edges.
    - Response: all outputs reach reset values with no clk edge.
